// File: rtl/rf_writeback_arbiter.sv
// Single-write-port register-file arbiter: merges the ALU writeback stream with a
// buffered in-order load-return FIFO, and reports in-flight writes per source register.
module rf_writeback_arbiter #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [31:0]              alu_wdata,
  output logic                     alu_stall,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [4:0]               lsu_rd,
  input  logic [31:0]              lsu_wdata,
  output logic                     rf_en,
  output logic [4:0]               rd,
  output logic [31:0]              wdata,
  input  logic [4:0]               chk_rs1,
  input  logic [4:0]               chk_rs2,
  output logic                     busy1,
  output logic                     busy2,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic [4:0]       mem_rd   [DEPTH];
  logic [31:0]      mem_data [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             rf_en_q, rf_en_d;
  logic [4:0]       rd_q, rd_d;
  logic [31:0]      wdata_q, wdata_d;

  logic fifo_ne, push, pop, take_alu;
  logic hit1, hit2;

  assign fifo_ne   = (count_q != '0);
  assign lsu_ready = (count_q < CW'(DEPTH));
  assign alu_stall = (starve_q == SW'(STARVE_MAX)) && fifo_ne;
  assign pop       = fifo_ne && (alu_stall || !alu_valid);
  assign take_alu  = alu_valid && !alu_stall;
  // Writes to x0 complete the handshake but are dropped before the FIFO.
  assign push      = lsu_valid && lsu_ready && (lsu_rd != '0);

  assign rf_en      = rf_en_q;
  assign rd         = rd_q;
  assign wdata      = wdata_q;
  assign fifo_count = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (push) begin
      wr_ptr_d          = wr_ptr_q + AW'(1);
      valid_d[wr_ptr_q] = 1'b1;
    end
    if (pop) begin
      rd_ptr_d          = rd_ptr_q + AW'(1);
      valid_d[rd_ptr_q] = 1'b0;
    end
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_comb begin
    starve_d = starve_q;
    if (pop || !fifo_ne) starve_d = '0;
    else                 starve_d = starve_q + SW'(1);
  end

  always_comb begin
    rf_en_d = 1'b0;
    rd_d    = rd_q;
    wdata_d = wdata_q;
    if (pop) begin
      rf_en_d = (mem_rd[rd_ptr_q] != '0);
      rd_d    = mem_rd[rd_ptr_q];
      wdata_d = mem_data[rd_ptr_q];
    end else if (take_alu) begin
      rf_en_d = (alu_rd != '0);
      rd_d    = alu_rd;
      wdata_d = alu_wdata;
    end
  end

  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (mem_rd[i] == chk_rs1)) hit1 = 1'b1;
      if (valid_q[i] && (mem_rd[i] == chk_rs2)) hit2 = 1'b1;
    end
    busy1 = (chk_rs1 != '0) && (hit1 || (rf_en_q && (rd_q == chk_rs1)));
    busy2 = (chk_rs2 != '0) && (hit2 || (rf_en_q && (rd_q == chk_rs2)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      starve_q <= '0;
      rf_en_q  <= 1'b0;
      rd_q     <= '0;
      wdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      starve_q <= starve_d;
      rf_en_q  <= rf_en_d;
      rd_q     <= rd_d;
      wdata_q  <= wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wr_ptr_q]   <= lsu_rd;
      mem_data[wr_ptr_q] <= lsu_wdata;
    end
  end

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter: reset, ALU path, starvation stall,
// busy tracking, FIFO full/back-pressure, wrap push/pop and mid-stream reset.
module tb_rf_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_wdata;
  logic        alu_stall;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_wdata;
  logic        rf_en;
  logic [4:0]  rd;
  logic [31:0] wdata;
  logic [4:0]  chk_rs1, chk_rs2;
  logic        busy1, busy2;
  logic [2:0]  fifo_count;

  int n_tests = 0;
  int n_fail  = 0;

  rf_writeback_arbiter #(.DEPTH(4), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wdata(alu_wdata), .alu_stall(alu_stall),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_wdata(lsu_wdata),
    .rf_en(rf_en), .rd(rd), .wdata(wdata),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .busy1(busy1), .busy2(busy2),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; alu_valid = 0; alu_rd = 0; alu_wdata = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_wdata = 0; chk_rs1 = 0; chk_rs2 = 0;
    #3;
    n_tests++; if (rf_en !== 1'b0) begin n_fail++; $display("FAIL reset_rf_en got %0b exp 0", rf_en); end
    n_tests++; if (rd !== 5'd0) begin n_fail++; $display("FAIL reset_rd got %0d exp 0", rd); end
    n_tests++; if (wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata got %h exp 0", wdata); end
    n_tests++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
    n_tests++; if (lsu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b exp 1", lsu_ready); end
    n_tests++; if (alu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %0b exp 0", alu_stall); end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    alu_valid = 1; alu_rd = 5; alu_wdata = 32'hDEADBEEF;
    lsu_valid = 1; lsu_rd = 0; lsu_wdata = 32'h5555;
    tick();
    lsu_valid = 0;
    n_tests++; if (rf_en !== 1'b1) begin n_fail++; $display("FAIL alu_rf_en got %0b exp 1", rf_en); end
    n_tests++; if (rd !== 5'd5) begin n_fail++; $display("FAIL alu_rd got %0d exp 5", rd); end
    n_tests++; if (wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_wdata got %h exp deadbeef", wdata); end
    n_tests++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL x0_load_discard count got %0d exp 0", fifo_count); end
    alu_rd = 0; alu_wdata = 32'h11;
    tick();
    n_tests++; if (rf_en !== 1'b0) begin n_fail++; $display("FAIL alu_x0_rf_en got %0b exp 0", rf_en); end
    alu_valid = 0;
    tick();
    n_tests++; if (rf_en !== 1'b0) begin n_fail++; $display("FAIL idle_rf_en got %0b exp 0", rf_en); end
    n_tests++; if (wdata !== 32'h11) begin n_fail++; $display("FAIL idle_hold_wdata got %h exp 11", wdata); end
  endtask

  task automatic test_starvation();
    alu_valid = 1; alu_rd = 3; alu_wdata = 32'hA5A5;
    lsu_valid = 1; lsu_rd = 7; lsu_wdata = 32'h1234;
    tick();
    lsu_valid = 0;
    for (int i = 0; i <= 6; i++) begin
      n_tests++;
      if (alu_stall !== (i == 4)) begin n_fail++; $display("FAIL starve_stall cyc %0d got %0b exp %0b", i, alu_stall, (i == 4)); end
      if (i == 5) begin
        n_tests++; if (rf_en !== 1'b1 || rd !== 5'd7 || wdata !== 32'h1234) begin n_fail++; $display("FAIL starve_load_write got en=%0b rd=%0d d=%h exp 1/7/1234", rf_en, rd, wdata); end
      end
      if (i == 6) begin
        n_tests++; if (rf_en !== 1'b1 || rd !== 5'd3 || wdata !== 32'hA5A5) begin n_fail++; $display("FAIL starve_held_alu got en=%0b rd=%0d d=%h exp 1/3/a5a5", rf_en, rd, wdata); end
      end
      tick();
    end
    alu_valid = 0;
    tick();
  endtask

  task automatic test_busy();
    chk_rs1 = 9; chk_rs2 = 0;
    alu_valid = 1; alu_rd = 3; alu_wdata = 32'h33;
    lsu_valid = 1; lsu_rd = 9; lsu_wdata = 32'h99;
    #1;
    n_tests++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL busy_same_cycle got %0b exp 0", busy1); end
    tick();
    lsu_valid = 0;
    for (int i = 0; i <= 6; i++) begin
      n_tests++;
      if (busy1 !== (i <= 5)) begin n_fail++; $display("FAIL busy1 cyc %0d got %0b exp %0b", i, busy1, (i <= 5)); end
      n_tests++;
      if (busy2 !== 1'b0) begin n_fail++; $display("FAIL busy2 cyc %0d got %0b exp 0", i, busy2); end
      if (i == 5) begin
        n_tests++; if (rf_en !== 1'b1 || rd !== 5'd9) begin n_fail++; $display("FAIL busy_write got en=%0b rd=%0d exp 1/9", rf_en, rd); end
      end
      tick();
    end
    alu_valid = 0; chk_rs1 = 0;
    tick();
  endtask

  task automatic test_full();
    logic exp_ready [7] = '{1, 1, 1, 1, 0, 0, 1};
    int k = 1;
    int nxt = 1;
    logic prev_stall = 1'b0;
    alu_valid = 1; alu_rd = 20; alu_wdata = 32'hA1;
    for (int c = 0; c < 40; c++) begin
      if (k <= 5) begin lsu_valid = 1; lsu_rd = 5'(k); lsu_wdata = 32'h100 + k; end
      else lsu_valid = 0;
      #1;
      if (c <= 6) begin
        n_tests++;
        if (lsu_ready !== exp_ready[c]) begin n_fail++; $display("FAIL full_ready cyc %0d got %0b exp %0b", c, lsu_ready, exp_ready[c]); end
      end
      if (rf_en === 1'b1 && rd !== 5'd20) begin
        n_tests++;
        if (rd !== 5'(nxt) || wdata !== 32'h100 + nxt || prev_stall !== 1'b1)
          begin n_fail++; $display("FAIL full_order got rd=%0d d=%h stall_before=%0b exp rd=%0d stall_before=1", rd, wdata, prev_stall, nxt); end
        nxt++;
      end
      if (lsu_valid && lsu_ready) k++;
      prev_stall = alu_stall;
      @(posedge clk); #1;
    end
    lsu_valid = 0;
    n_tests++; if (nxt !== 6) begin n_fail++; $display("FAIL full_all_written got %0d loads exp 5", nxt - 1); end
    alu_valid = 0;
    tick();
    n_tests++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL full_drained count got %0d exp 0", fifo_count); end
  endtask

  task automatic test_wrap();
    // Pointers sit at 3 here after seven pushes/pops in the earlier tests.
    alu_valid = 1; alu_rd = 20; alu_wdata = 32'h20;
    lsu_valid = 1; lsu_rd = 10; lsu_wdata = 32'hA0;
    tick();
    lsu_rd = 11; lsu_wdata = 32'hB0;
    tick();
    n_tests++; if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL wrap_pre_count got %0d exp 2", fifo_count); end
    alu_valid = 0; lsu_rd = 12; lsu_wdata = 32'hC0;
    tick();
    lsu_valid = 0;
    n_tests++; if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL wrap_pushpop_count got %0d exp 2", fifo_count); end
    n_tests++; if (rf_en !== 1'b1 || rd !== 5'd10 || wdata !== 32'hA0) begin n_fail++; $display("FAIL wrap_first got en=%0b rd=%0d d=%h exp 1/10/a0", rf_en, rd, wdata); end
    tick();
    n_tests++; if (rf_en !== 1'b1 || rd !== 5'd11 || wdata !== 32'hB0) begin n_fail++; $display("FAIL wrap_second got en=%0b rd=%0d d=%h exp 1/11/b0", rf_en, rd, wdata); end
    tick();
    n_tests++; if (rf_en !== 1'b1 || rd !== 5'd12 || wdata !== 32'hC0) begin n_fail++; $display("FAIL wrap_third got en=%0b rd=%0d d=%h exp 1/12/c0", rf_en, rd, wdata); end
    n_tests++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL wrap_end_count got %0d exp 0", fifo_count); end
    tick();
  endtask

  task automatic test_reset_midstream();
    alu_valid = 1; alu_rd = 20; alu_wdata = 32'h20; chk_rs1 = 13;
    for (int i = 0; i < 3; i++) begin
      lsu_valid = 1; lsu_rd = 5'(13 + i); lsu_wdata = 32'hF0 + i;
      tick();
    end
    lsu_valid = 0;
    #1;
    n_tests++; if (fifo_count !== 3'd3 || rf_en !== 1'b1) begin n_fail++; $display("FAIL rst_pre got count=%0d en=%0b exp 3/1", fifo_count, rf_en); end
    n_tests++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL rst_pre_busy got %0b exp 1", busy1); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (rf_en !== 1'b0 || rd !== 5'd0 || wdata !== 32'd0) begin n_fail++; $display("FAIL rst_async_out got en=%0b rd=%0d d=%h exp 0/0/0", rf_en, rd, wdata); end
    n_tests++; if (fifo_count !== 3'd0 || lsu_ready !== 1'b1 || alu_stall !== 1'b0) begin n_fail++; $display("FAIL rst_async_ctl got count=%0d rdy=%0b stall=%0b exp 0/1/0", fifo_count, lsu_ready, alu_stall); end
    n_tests++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy got %0b/%0b exp 0/0", busy1, busy2); end
    alu_valid = 0;
    @(negedge clk); rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (rf_en !== 1'b0 || lsu_ready !== 1'b1) begin n_fail++; $display("FAIL rst_post cyc %0d got en=%0b rd=%0d rdy=%0b exp en=0 rdy=1", i, rf_en, rd, lsu_ready); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_starvation();
    test_busy();
    test_full();
    test_wrap();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_writeback_arbiter.md
# rf_writeback_arbiter

Single-write-port arbiter sitting in front of the 32x32 integer register file. It merges the ALU writeback stream, which cannot be back-pressured except through a starvation stall, with the load-unit return stream, which is handshaked and buffered in a small in-order FIFO. It drives the register file's write port (`rf_en`, `rd`, `wdata`) from a registered output stage. It also reports, per read port, whether a source register still has a write in flight, so the core's stall logic can hold dependent instructions.

## Interface
- `DEPTH`, 4: load-return FIFO entries (power of two, >= 2)
- `STARVE_MAX`, 4: consecutive cycles a non-empty FIFO may lose arbitration before ALU is stalled
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `alu_valid`  in  1  ALU result valid this cycle
- `alu_rd`  in  5  ALU destination register
- `alu_wdata`  in  32  ALU result
- `alu_stall`  out  1  ALU result not taken this cycle; core holds `alu_*` stable
- `lsu_valid`  in  1  load data valid
- `lsu_ready`  out  1  FIFO can accept
- `lsu_rd`  in  5  load destination register
- `lsu_wdata`  in  32  load data
- `rf_en`  out  1  register file write enable (registered)
- `rd`  out  5  register file write address (registered)
- `wdata`  out  32  register file write data (registered)
- `chk_rs1`, `chk_rs2`  in  5 each  source registers to check
- `busy1`, `busy2`  out  1 each  write pending to `chk_rs1` / `chk_rs2`
- `fifo_count`  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- **Load push:** a push occurs when `lsu_valid && lsu_ready`.
  - `lsu_ready = (fifo_count < DEPTH)`. It depends on registered state only, so there is no same-cycle pop pass-through; a full FIFO with a simultaneous pop still refuses.
  - A push with `lsu_rd == 0` completes the handshake but is discarded and never enters the FIFO.
- **Arbitration:** evaluated each cycle, first match wins.
  1. `alu_stall` = 1: pop the FIFO head to the output stage. The ALU result is ignored.
  2. `alu_valid` = 1: take the ALU result.
  3. FIFO non-empty: pop the head.
  4. Otherwise, idle.
- **Starvation counter:**
  - Increments each cycle the FIFO is non-empty and not popped.
  - Clears on any pop, or when the FIFO is empty.
  - `alu_stall = (starve_cnt == STARVE_MAX) && fifo_non_empty`. It is combinational from registered state and lasts exactly one cycle per event.
- **Output stage:**
  - The selected write is registered into `rf_en`/`rd`/`wdata`.
  - Selected `rd == 0` gives `rf_en = 0`.
  - When idle, `rf_en = 0`; `rd` and `wdata` hold their last values.
- **Busy:** `busyN = (chk_rsN != 0) && (any valid FIFO entry has rd == chk_rsN || (rf_en && rd == chk_rsN))`.
  - Same-cycle pushes are excluded.
  - The core must not issue an ALU write to a register that is busy. WAW ordering between ALU and loads is the core's responsibility.
- **FIFO:**
  - Strict in-order, circular, wrap-around pointers.
  - A push and a pop in the same cycle leave `fifo_count` unchanged.

## Timing
- **Reset (async assert, sync-safe deassert):**
  - `rf_en` = 0, `rd` = 0, `wdata` = 0, `fifo_count` = 0, starve counter = 0.
  - Hence `lsu_ready` = 1, `alu_stall` = 0, `busy1` = `busy2` = 0.
  - Reset mid-operation discards all FIFO contents and any pending output write.
- **ALU latency:** ALU accepted in cycle N gives `rf_en` = 1 in cycle N+1. The register file updates at the end of N+1, and the value is readable in N+2.
- **Load latency:** a load pushed in cycle N is earliest popped in N+1 and appears on `rf_en` in N+2.
- **Busy:** `busy` asserts the cycle after the push and stays asserted through the cycle in which `rf_en` presents the write.
- **Starvation bound:** under continuous `alu_valid`, the FIFO head waits at most `STARVE_MAX` + 1 cycles.

## Test plan
- **Reset:**
  - Stimulus: assert `rst_n` = 0 mid-stream with FIFO count 3 and `rf_en` = 1.
  - Response: all outputs go to the reset values immediately. After release, `lsu_ready` = 1 and the old entries are never written.
- **ALU only:**
  - Stimulus: `alu_valid` = 1, `alu_rd` = 5, `alu_wdata` = 0xDEADBEEF in cycle N.
  - Response: cycle N+1 shows `rf_en` = 1, `rd` = 5, `wdata` = 0xDEADBEEF. The same stimulus with `alu_rd` = 0 gives `rf_en` = 0.
- **Load buffering and full:**
  - Stimulus: 5 back-to-back loads to x1..x5 while `alu_valid` = 1 continuously.
  - Response: `lsu_ready` drops after the 4th push. The writes x1..x4 emerge in order, one per stall event. x5 is accepted once the count is below 4.
- **Starvation:**
  - Stimulus: one load to x7 (0x1234), then `alu_valid` held high.
  - Response: `alu_stall` = 1 in exactly one cycle, 4 cycles after the FIFO becomes non-empty. The next cycle shows `rd` = 7, `wdata` = 0x1234, and the held ALU result is written the cycle after.
- **Busy:**
  - Stimulus: load to x9 pushed while the ALU is busy, with `chk_rs1` = 9 and `chk_rs2` = 0.
  - Response: `busy1` = 1 from the cycle after the push until the cycle `rf_en` presents x9 (inclusive), then 0. `busy2` stays 0.
- **Simultaneous push/pop at wrap:**
  - Stimulus: with count 2 and pointers at `DEPTH`-1, push and pop in the same cycle.
  - Response: count stays 2, the pointers wrap to 0, and data order is preserved.
